// File: rtl/ritc_delay_scan_pkg.sv
// ============================================================================
// Module      : ritc_delay_scan_pkg
// Description : Shared types and constants for the RITC IDELAY eye scanner:
//               scan state encoding, tap geometry and the address decode
//               that rejects non-existent channels and bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ritc_delay_scan_pkg;

    localparam int NTAPS = 32;
    localparam int TAP_W = 5;

    localparam logic [TAP_W-1:0] c_LAST_TAP = TAP_W'(NTAPS - 1);

    // Channel 3 does not exist; bits 12-14 sit between data bits and the clock.
    localparam logic [1:0] c_CHAN_INVALID = 2'd3;
    localparam logic [3:0] c_BIT_RSVD_LO  = 4'd12;
    localparam logic [3:0] c_BIT_RSVD_HI  = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_RDY   = 3'd1,
        ST_LOAD       = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_SAMPLE     = 3'd4,
        ST_EVAL       = 3'd5,
        ST_FINAL_LOAD = 3'd6,
        ST_DONE       = 3'd7
    } scan_state_t;

    // True when the requested target bit cannot be scanned.
    function automatic logic addr_invalid(input logic [5:0] a);
        return (a[5:4] == c_CHAN_INVALID) ||
               ((a[3:0] >= c_BIT_RSVD_LO) && (a[3:0] <= c_BIT_RSVD_HI));
    endfunction

endpackage

`default_nettype wire

// File: rtl/ritc_delay_scan_if.sv
// ============================================================================
// Module      : ritc_delay_scan_if
// Description : IDELAY programming bus between the scanner (master) and the
//               delay-line block (slave): tap value, address, load strobe and
//               per-group IDELAYCTRL ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ritc_delay_scan_if;
    import ritc_delay_scan_pkg::*;

    logic [TAP_W-1:0] delay_o;
    logic [5:0]       addr_o;
    logic             load_o;
    logic [2:0]       ready_i;

    modport master (output delay_o, output addr_o, output load_o, input ready_i);
    modport slave  (input delay_o, input addr_o, input load_o, output ready_i);

endinterface

`default_nettype wire

// File: rtl/ritc_scan_window_tracker.sv
// ============================================================================
// Module      : ritc_scan_window_tracker
// Description : Tracks the current run of error-free taps and remembers the
//               widest run seen so far. Ties keep the earlier window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ritc_scan_window_tracker
    import ritc_delay_scan_pkg::*;
(
    input  wire logic             CLK,
    input  wire logic             rst_n_i,
    input  wire logic             i_clear,
    input  wire logic             i_clean,
    input  wire logic             i_strobe,
    input  wire logic [TAP_W-1:0] i_tap,
    output logic      [TAP_W-1:0] o_best_start,
    output logic      [TAP_W:0]   o_best_len
);

    logic [TAP_W-1:0] r_run_start;
    logic [TAP_W:0]   r_run_len;
    logic [TAP_W-1:0] r_best_start;
    logic [TAP_W:0]   r_best_len;
    logic [TAP_W-1:0] w_run_start;
    logic [TAP_W:0]   w_run_len;

    // Run values after evaluating the current tap.
    always_comb begin
        w_run_len   = i_clean ? (r_run_len + (TAP_W+1)'(1)) : '0;
        w_run_start = (i_clean && (r_run_len == '0)) ? i_tap : r_run_start;
    end

    // Commit run and strictly-wider best window on each evaluation strobe.
    always_ff @(posedge CLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_clear) begin
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_strobe) begin
            r_run_start <= w_run_start;
            r_run_len   <= w_run_len;
            if (w_run_len > r_best_len) begin
                r_best_len   <= w_run_len;
                r_best_start <= w_run_start;
            end
        end
    end

    assign o_best_start = r_best_start;
    assign o_best_len   = r_best_len;

endmodule

`default_nettype wire

// File: rtl/ritc_delay_scan.sv
// ============================================================================
// Module      : ritc_delay_scan
// Description : Sweeps all 32 IDELAY taps for one RITC input bit, counts
//               alternating-pattern errors per tap, and loads the centre of
//               the widest error-free window. Optional macro
//               RITC_DELAY_SCAN_ERRLOG_EN adds a readable per-tap error RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ritc_delay_scan
    import ritc_delay_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES_LOG2  = 8
)(
    input  wire logic             CLK,
    input  wire logic             rst_n_i,
    input  wire logic             start_i,
    input  wire logic [5:0]       addr_i,
    input  wire logic             bit_i,
    input  wire logic             bit_valid_i,
    ritc_delay_scan_if.master     idly,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic      [TAP_W-1:0] best_tap_o,
    output logic      [TAP_W:0]   window_len_o
`ifdef RITC_DELAY_SCAN_ERRLOG_EN
    ,
    input  wire logic [TAP_W-1:0]    err_rd_addr_i,
    output logic      [SAMPLES_LOG2:0] err_rd_dat_o
`endif
);

    localparam int c_ERR_W    = SAMPLES_LOG2 + 1;
    localparam int c_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_CYCLES - 1);

    scan_state_t             r_state, w_next;
    logic [TAP_W-1:0]        r_tap, r_delay, w_delay;
    logic [5:0]              r_addr;
    logic [c_SETTLE_W-1:0]   r_settle;
    logic [SAMPLES_LOG2-1:0] r_samp;
    logic [c_ERR_W-1:0]      r_err;
    logic                    r_prev, r_have_prev;
    logic                    r_busy, r_done, r_fail;
    logic [TAP_W-1:0]        r_best_tap;
    logic [TAP_W:0]          r_window_len;
    logic                    w_rdy, w_accept, w_bad_addr, w_load, w_strobe, w_clean, w_sample_err;
    logic [TAP_W-1:0]        w_best_start, w_best_tap;
    logic [TAP_W:0]          w_best_len;

    // Ready of the channel group being scanned; a non-existent group is never ready.
    always_comb begin
        case (r_addr[5:4])
            2'd0:    w_rdy = idly.ready_i[0];
            2'd1:    w_rdy = idly.ready_i[1];
            2'd2:    w_rdy = idly.ready_i[2];
            default: w_rdy = 1'b0;
        endcase
    end

    // Window centre; a clamped sum is unnecessary since start + len never exceeds 32.
    always_comb begin
        w_best_tap   = (w_best_len == '0) ? '0 : (w_best_start + w_best_len[TAP_W:1]);
        w_clean      = (r_err == '0);
        w_bad_addr   = addr_invalid(addr_i);
        w_sample_err = r_have_prev && (bit_i == r_prev);
    end

    // Scan sequencing; load is gated by ready so it can never fire with ready low.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_load   = 1'b0;
        w_strobe = 1'b0;
        w_delay  = r_delay;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    w_next   = w_bad_addr ? ST_DONE : ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (w_rdy) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_delay = r_tap;
                if (w_rdy) begin
                    w_load = 1'b1;
                    w_next = ST_SETTLE;
                end else begin
                    w_next = ST_WAIT_RDY;
                end
            end
            ST_SETTLE: begin
                if (!w_rdy)                       w_next = ST_WAIT_RDY;
                else if (r_settle == c_SETTLE_LAST) w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (!w_rdy)                         w_next = ST_WAIT_RDY;
                else if (bit_valid_i && (&r_samp))  w_next = ST_EVAL;
            end
            ST_EVAL: begin
                w_strobe = 1'b1;
                w_next   = (r_tap == c_LAST_TAP) ? ST_FINAL_LOAD : ST_WAIT_RDY;
            end
            ST_FINAL_LOAD: begin
                w_delay = w_best_tap;
                if (w_rdy) begin
                    w_load = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Tap, address and status registers; later assignments take priority.
    always_ff @(posedge CLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_delay      <= '0;
            r_tap        <= '0;
            r_addr       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_best_tap   <= '0;
            r_window_len <= '0;
        end else begin
            r_delay <= w_delay;
            if (w_accept) begin
                r_addr       <= addr_i;
                r_tap        <= '0;
                r_done       <= 1'b0;
                r_fail       <= w_bad_addr;
                r_busy       <= ~w_bad_addr;
                r_best_tap   <= '0;
                r_window_len <= '0;
            end
            if ((r_state == ST_EVAL) && (r_tap != c_LAST_TAP)) r_tap <= r_tap + TAP_W'(1);
            if ((r_state == ST_FINAL_LOAD) && w_rdy) begin
                r_best_tap   <= w_best_tap;
                r_window_len <= w_best_len;
                r_fail       <= (w_best_len == '0);
            end
            if (w_next == ST_DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    // Settle timer and sample/error counters; cleared outside their states
    // so an aborted tap restarts from scratch.
    always_ff @(posedge CLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_settle    <= '0;
            r_samp      <= '0;
            r_err       <= '0;
            r_prev      <= 1'b0;
            r_have_prev <= 1'b0;
        end else begin
            r_settle <= (r_state == ST_SETTLE) ? (r_settle + c_SETTLE_W'(1)) : '0;
            if (r_state != ST_SAMPLE) begin
                r_samp      <= '0;
                r_err       <= '0;
                r_prev      <= 1'b0;
                r_have_prev <= 1'b0;
            end else if (bit_valid_i) begin
                r_samp      <= r_samp + SAMPLES_LOG2'(1);
                r_prev      <= bit_i;
                r_have_prev <= 1'b1;
                if (w_sample_err && !(&r_err)) r_err <= r_err + c_ERR_W'(1);
            end
        end
    end

    ritc_scan_window_tracker u_tracker (
        .CLK          (CLK),
        .rst_n_i      (rst_n_i),
        .i_clear      (w_accept),
        .i_clean      (w_clean),
        .i_strobe     (w_strobe),
        .i_tap        (r_tap),
        .o_best_start (w_best_start),
        .o_best_len   (w_best_len)
    );

`ifdef RITC_DELAY_SCAN_ERRLOG_EN
    logic [c_ERR_W-1:0] r_err_ram [0:NTAPS-1];
    logic [c_ERR_W-1:0] r_err_rd;

    // Per-tap error log, written at evaluation, read with one cycle latency.
    always_ff @(posedge CLK) begin
        if (w_strobe) r_err_ram[r_tap] <= r_err;
        r_err_rd <= r_err_ram[err_rd_addr_i];
    end

    assign err_rd_dat_o = r_err_rd;
`endif

    assign idly.delay_o = w_delay;
    assign idly.addr_o  = r_addr;
    assign idly.load_o  = w_load;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign fail_o       = r_fail;
    assign best_tap_o   = r_best_tap;
    assign window_len_o = r_window_len;

endmodule

`default_nettype wire
